// File: rtl/palette_lut.sv
// ---------------------------------------------------------------------------
// PaletteLut (module palette_lut)
//
// Purpose
//   Writable multi-bank colour palette. A pixel index is mapped to a DATA_W-bit
//   colour through a fixed two-stage registered read pipeline. The palette sits
//   between the sprite/background index generators and the VGA output mux.
//   NUM_BANKS complete palettes are stored. The displayed bank changes only on
//   a frame_start pulse, so a bank switch never tears a frame. After reset, the
//   block walks every entry of every bank and reloads the standard game palette.
//
// Optional feature
//   PALETTE_TRANSP_EN : when defined, o_color_transp is registered alongside
//                       o_color_data. It is 1 when the looked-up index equals
//                       TRANSP_INDEX. When undefined, o_color_transp is tied 0
//                       and no compare logic exists.
//
// Ports
//   i_clk            system clock, all logic on the rising edge
//   i_reset          synchronous, active-high reset
//   i_frame_start    1-cycle pulse at start of vertical blank
//   i_bank_sel       requested display bank, sampled on i_frame_start
//   i_rd_valid       read request qualifier
//   i_rd_index       pixel index to look up
//   o_color_valid    o_color_data valid (2 cycles after i_rd_valid)
//   o_color_data     looked-up colour, holds while o_color_valid=0
//   o_color_transp   looked-up index equalled TRANSP_INDEX
//   i_wr_en          palette write strobe, accepted only when o_wr_ready=1
//   i_wr_bank        bank written
//   i_wr_addr        entry written
//   i_wr_data        colour written
//   o_wr_ready       0 during init, else 1
//   o_init_busy      1 while default contents are being loaded
//   o_active_bank    bank currently used for reads
// ---------------------------------------------------------------------------
module palette_lut #(
  parameter int INDEX_W      = 4,
  parameter int DATA_W       = 24,
  parameter int NUM_BANKS    = 4,
  parameter int TRANSP_INDEX = 0,
  localparam int BANK_W      = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_frame_start,
  input  logic [BANK_W-1:0]   i_bank_sel,
  input  logic                i_rd_valid,
  input  logic [INDEX_W-1:0]  i_rd_index,
  output logic                o_color_valid,
  output logic [DATA_W-1:0]   o_color_data,
  output logic                o_color_transp,
  input  logic                i_wr_en,
  input  logic [BANK_W-1:0]   i_wr_bank,
  input  logic [INDEX_W-1:0]  i_wr_addr,
  input  logic [DATA_W-1:0]   i_wr_data,
  output logic                o_wr_ready,
  output logic                o_init_busy,
  output logic [BANK_W-1:0]   o_active_bank
);

  localparam int DEPTH     = 2 ** INDEX_W;
  localparam int ADDR_W    = BANK_W + INDEX_W;
  localparam int MEM_DEPTH = NUM_BANKS * DEPTH;

  // Bank numbers at or above this limit only exist when NUM_BANKS is not a
  // power of two; such selections and writes are discarded.
  localparam logic [BANK_W:0]    BANK_LIMIT = (BANK_W + 1)'(NUM_BANKS);
  localparam logic [BANK_W-1:0]  LAST_BANK  = BANK_W'(NUM_BANKS - 1);
  localparam logic [INDEX_W-1:0] LAST_ENTRY = INDEX_W'(DEPTH - 1);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Standard game palette. Indices 16 and up load black. Narrower or wider
  // colour words keep the low DATA_W bits of the RGB888 value, zero-extended.
  function automatic logic [DATA_W-1:0] std_color(input logic [INDEX_W-1:0] idx);
    logic [23:0] rgb;
    int unsigned i;
    i = idx;
    case (i)
      0:       rgb = 24'h008000;
      1:       rgb = 24'hb9886a;
      2:       rgb = 24'hf5d1b9;
      3:       rgb = 24'hffd7b1;
      4:       rgb = 24'h303028;
      5:       rgb = 24'h84583d;
      6:       rgb = 24'hc29983;
      7:       rgb = 24'hffffff;
      8:       rgb = 24'ha00000;
      9:       rgb = 24'hb9886a;
      10:      rgb = 24'hf8f8c0;
      11:      rgb = 24'h000000;
      12:      rgb = 24'h431a00;
      13:      rgb = 24'h63371d;
      14:      rgb = 24'h874e2b;
      15:      rgb = 24'hffbfbf;
      default: rgb = 24'h000000;
    endcase
    return DATA_W'(rgb);
  endfunction

  logic [0:0]         r_state;
  logic [BANK_W-1:0]  r_init_bank;
  logic [INDEX_W-1:0] r_init_addr;
  logic [BANK_W-1:0]  r_active_bank;

  logic [DATA_W-1:0]  r_mem [MEM_DEPTH];

  logic               r_s1_valid;
  logic [DATA_W-1:0]  r_s1_data;
  logic               r_color_valid;
  logic [DATA_W-1:0]  r_color_data;

  logic               w_run;
  logic               w_init_last;
  logic               w_wr_fire;
  logic               w_rd_fire;
  logic               w_bank_switch;
  logic               w_mem_we;
  logic [ADDR_W-1:0]  w_mem_waddr;
  logic [DATA_W-1:0]  w_mem_wdata;
  logic [ADDR_W-1:0]  w_rd_ptr;

  assign w_run         = (r_state == ST_RUN);
  assign w_init_last   = (r_init_bank == LAST_BANK) && (r_init_addr == LAST_ENTRY);
  assign w_wr_fire     = w_run && i_wr_en && ({1'b0, i_wr_bank} < BANK_LIMIT);
  assign w_rd_fire     = w_run && i_rd_valid;
  assign w_bank_switch = w_run && i_frame_start && ({1'b0, i_bank_sel} < BANK_LIMIT);

  // The read address combines the currently active bank with the request
  // index. The bank is therefore bound to a read in the cycle it is issued, and
  // a later frame_start cannot redirect a read that is already in flight.
  assign w_rd_ptr = {r_active_bank, i_rd_index};

  // Init sequencing: one entry per cycle, bank-major. The last entry moves the
  // block to RUN on the following cycle. Reset restarts the walk from entry 0
  // no matter where it was.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_INIT;
      r_init_bank <= '0;
      r_init_addr <= '0;
    end else if (r_state == ST_INIT) begin
      if (w_init_last) begin
        r_state <= ST_RUN;
      end else begin
        r_init_addr <= r_init_addr + 1'b1;
        if (r_init_addr == LAST_ENTRY) begin
          r_init_bank <= r_init_bank + 1'b1;
        end
      end
    end
  end

  // Active bank only moves on a frame_start in RUN, so the displayed palette
  // changes at a frame boundary. Out-of-range requests leave it alone.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_active_bank <= '0;
    end else if (w_bank_switch) begin
      r_active_bank <= i_bank_sel;
    end
  end

  // Single write port shared between the init loader and host writes. The two
  // never compete because host writes are only accepted in RUN.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_waddr = {i_wr_bank, i_wr_addr};
    w_mem_wdata = i_wr_data;
    if (!i_reset) begin
      if (r_state == ST_INIT) begin
        w_mem_we    = 1'b1;
        w_mem_waddr = {r_init_bank, r_init_addr};
        w_mem_wdata = std_color(r_init_addr);
      end else if (w_wr_fire) begin
        w_mem_we = 1'b1;
      end
    end
  end

  // Palette storage, no reset so it maps onto block RAM. The init walk provides
  // the defined contents.
  always_ff @(posedge i_clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_waddr] <= w_mem_wdata;
    end
  end

  // Stage 1: the RAM is read on the same edge as the request. A write to the
  // same entry in that cycle is not yet visible. This gives read-before-write,
  // and every later read sees the new colour.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_valid <= w_rd_fire;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_rd_fire) begin
      r_s1_data <= r_mem[w_rd_ptr];
    end
  end

  // Stage 2: output register. The colour holds its last value between valid
  // beats so the downstream mux sees a stable word.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_color_valid <= 1'b0;
      r_color_data  <= '0;
    end else begin
      r_color_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_color_data <= r_s1_data;
      end
    end
  end

`ifdef PALETTE_TRANSP_EN
  logic [INDEX_W-1:0] r_s1_index;
  logic               r_color_transp;

  // The index travels with the read so the transparency flag lines up with
  // its colour word.
  always_ff @(posedge i_clk) begin
    if (w_rd_fire) begin
      r_s1_index <= i_rd_index;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_color_transp <= 1'b0;
    end else if (r_s1_valid) begin
      r_color_transp <= (r_s1_index == INDEX_W'(TRANSP_INDEX));
    end
  end

  assign o_color_transp = r_color_transp;
`else
  assign o_color_transp = 1'b0;
`endif

  assign o_color_valid = r_color_valid;
  assign o_color_data  = r_color_data;
  assign o_wr_ready    = w_run;
  assign o_init_busy   = ~w_run;
  assign o_active_bank = r_active_bank;

endmodule

// File: tb/tb_palette_lut.sv
// ---------------------------------------------------------------------------
// TbPaletteLut (module tb_palette_lut)
//
// Purpose
//   Self-checking bench for palette_lut at its default parameters. A
//   behavioural palette model (bank array, active bank, queue of reads due
//   back) predicts every output on every cycle. Directed vectors with
//   hand-computed colours pin the model itself. Define PALETTE_TRANSP_EN to
//   check the transparency flag.
// ---------------------------------------------------------------------------
module tb_palette_lut;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frameStart = 1'b0;
  logic [1:0]  bankSel = '0;
  logic        rdValid = 1'b0;
  logic [3:0]  rdIndex = '0;
  logic        colorValid;
  logic [23:0] colorData;
  logic        colorTransp;
  logic        wrEn = 1'b0;
  logic [1:0]  wrBank = '0;
  logic [3:0]  wrAddr = '0;
  logic [23:0] wrData = '0;
  logic        wrReady;
  logic        initBusy;
  logic [1:0]  activeBank;

  int vectors = 0;
  int miscompares = 0;

  palette_lut dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_frame_start  (frameStart),
    .i_bank_sel     (bankSel),
    .i_rd_valid     (rdValid),
    .i_rd_index     (rdIndex),
    .o_color_valid  (colorValid),
    .o_color_data   (colorData),
    .o_color_transp (colorTransp),
    .i_wr_en        (wrEn),
    .i_wr_bank      (wrBank),
    .i_wr_addr      (wrAddr),
    .i_wr_data      (wrData),
    .o_wr_ready     (wrReady),
    .o_init_busy    (initBusy),
    .o_active_bank  (activeBank)
  );

  always #5 clk = ~clk;

  // Compares one value and counts it. A miss prints a single FAIL line.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Standard palette as listed for the product, written out here independently.
  logic [23:0] stdColors [16] = '{
    24'h008000, 24'hb9886a, 24'hf5d1b9, 24'hffd7b1,
    24'h303028, 24'h84583d, 24'hc29983, 24'hffffff,
    24'ha00000, 24'hb9886a, 24'hf8f8c0, 24'h000000,
    24'h431a00, 24'h63371d, 24'h874e2b, 24'hffbfbf
  };

  typedef struct {
    int          due;
    logic [23:0] data;
    logic        transp;
  } readT;

  readT        pending[$];
  readT        newRead;
  logic [23:0] mMem [4][16];
  int          cyc = 0;
  int          mInitLeft = 0;
  int          mBank = 0;
  int          initPos;
  logic        mStarted = 1'b0;
  logic [23:0] mLastData = '0;
  logic        mLastTransp = 1'b0;
  logic        expValid;

  // Behavioural model. Inputs are driven on the falling edge, so they are
  // stable when this samples them at the rising edge. A read captures the
  // palette as it stands before any same-cycle write, and it is due on the
  // output one edge later.
  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      mStarted    = 1'b1;
      mInitLeft   = 64;
      mBank       = 0;
      mLastData   = '0;
      mLastTransp = 1'b0;
      pending.delete();
    end else if (mInitLeft > 0) begin
      initPos = 64 - mInitLeft;
      mMem[initPos / 16][initPos % 16] = stdColors[initPos % 16];
      mInitLeft--;
    end else begin
      if (rdValid) begin
        newRead.due  = cyc + 1;
        newRead.data = mMem[mBank][rdIndex];
`ifdef PALETTE_TRANSP_EN
        newRead.transp = (rdIndex == 4'd0);
`else
        newRead.transp = 1'b0;
`endif
        pending.push_back(newRead);
      end
      if (wrEn) mMem[wrBank][wrAddr] = wrData;
      if (frameStart) mBank = bankSel;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (mStarted) begin
      expValid = (pending.size() > 0) && (pending[0].due == cyc);
      if (expValid) begin
        mLastData   = pending[0].data;
        mLastTransp = pending[0].transp;
        void'(pending.pop_front());
      end
      checkOutput("colorValid", 32'(colorValid), 32'(expValid));
      checkOutput("colorData", 32'(colorData), 32'(mLastData));
      checkOutput("colorTransp", 32'(colorTransp), 32'(mLastTransp));
      checkOutput("initBusy", 32'(initBusy), 32'(mInitLeft > 0));
      checkOutput("wrReady", 32'(wrReady), 32'(mInitLeft == 0));
      checkOutput("activeBank", 32'(activeBank), 32'(mBank));
    end
  end

  // Drives one cycle of inputs from a falling edge and returns on the next one.
  task automatic applyStimulus(input logic rdv, input logic [3:0] ridx,
                               input logic wen, input logic [1:0] wbank,
                               input logic [3:0] waddr, input logic [23:0] wdata,
                               input logic fs, input logic [1:0] bsel);
    rdValid    = rdv;
    rdIndex    = ridx;
    wrEn       = wen;
    wrBank     = wbank;
    wrAddr     = waddr;
    wrData     = wdata;
    frameStart = fs;
    bankSel    = bsel;
    @(negedge clk);
  endtask

  task automatic applyIdle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, bankSel);
  endtask

  // Releases reset and counts init cycles, with a bound. With noisy set, it
  // also keeps reads, writes and frame_start active throughout init. All of
  // them must be ignored.
  task automatic releaseReset(input string name, input logic noisy);
    int cnt;
    cnt = 0;
    reset = 1'b0;
    while (initBusy === 1'b1 && cnt < 200) begin
      cnt++;
      if (noisy) applyStimulus(1, 4'd3, 1, 2'd0, 4'd3, 24'h111111, 1, 2'd2);
      else       applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    end
    checkOutput({name, "_initLen"}, 32'(cnt), 32'd64);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_initBusy", 32'(initBusy), 32'd1);
    checkOutput("rst_wrReady", 32'(wrReady), 32'd0);
    checkOutput("rst_colorValid", 32'(colorValid), 32'd0);
    checkOutput("rst_colorData", 32'(colorData), 32'd0);
    checkOutput("rst_activeBank", 32'(activeBank), 32'd0);

    // Default contents and latency 2. Writes during init were ignored.
    releaseReset("t1", 1'b1);
    applyStimulus(1, 4'd3, 0, 0, 0, 0, 0, 0);
    checkOutput("t1_lat1_valid", 32'(colorValid), 32'd0);
    applyIdle(1);
    checkOutput("t1_lat2_valid", 32'(colorValid), 32'd1);
    checkOutput("t1_idx3", 32'(colorData), 32'h00ffd7b1);
    applyIdle(1);
    checkOutput("t1_hold", 32'(colorData), 32'h00ffd7b1);

    // Back-to-back reads at full throughput.
    applyStimulus(1, 4'd0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 4'd7, 0, 0, 0, 0, 0, 0);
    checkOutput("t2_idx0", 32'(colorData), 32'h00008000);
    applyStimulus(1, 4'd8, 0, 0, 0, 0, 0, 0);
    checkOutput("t2_idx7", 32'(colorData), 32'h00ffffff);
    applyIdle(1);
    checkOutput("t2_idx8", 32'(colorData), 32'h00a00000);
    checkOutput("t2_idx8_valid", 32'(colorValid), 32'd1);

    // Write bank 1, then request bank 1 without frame_start. The bank must not move.
    applyStimulus(0, 0, 1, 2'd1, 4'd5, 24'h123456, 0, 2'd1);
    applyStimulus(1, 4'd5, 0, 0, 0, 0, 0, 2'd1);
    applyIdle(1);
    checkOutput("t3_noswitch", 32'(colorData), 32'h0084583d);
    checkOutput("t3_bank0", 32'(activeBank), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 2'd1);
    checkOutput("t3_bank1", 32'(activeBank), 32'd1);
    applyStimulus(1, 4'd5, 0, 0, 0, 0, 0, 2'd1);
    applyIdle(1);
    checkOutput("t3_newcolor", 32'(colorData), 32'h00123456);

    // A read and a write to the same entry in one cycle: the read returns the old value.
    applyStimulus(1, 4'd9, 1, 2'd1, 4'd9, 24'habcdef, 0, 2'd1);
    applyStimulus(1, 4'd9, 0, 0, 0, 0, 0, 2'd1);
    checkOutput("t4_rbw_old", 32'(colorData), 32'h00b9886a);
    applyIdle(1);
    checkOutput("t4_after", 32'(colorData), 32'h00abcdef);

    // Transparency flag for index 0 and index 1.
    applyStimulus(1, 4'd0, 0, 0, 0, 0, 0, 2'd1);
    applyStimulus(1, 4'd1, 0, 0, 0, 0, 0, 2'd1);
    checkOutput("t6_idx0_data", 32'(colorData), 32'h00008000);
`ifdef PALETTE_TRANSP_EN
    checkOutput("t6_idx0_transp", 32'(colorTransp), 32'd1);
`else
    checkOutput("t6_idx0_transp", 32'(colorTransp), 32'd0);
`endif
    applyIdle(1);
    checkOutput("t6_idx1_data", 32'(colorData), 32'h00b9886a);
    checkOutput("t6_idx1_transp", 32'(colorTransp), 32'd0);

    // Reset at init cycle 30. Init must restart and take the full 64 cycles.
    reset = 1'b1;
    applyIdle(1);
    reset = 1'b0;
    for (int i = 0; i < 30; i++) applyStimulus(1, 4'd5, 1, 2'd0, 4'd3, 24'h222222, 1, 2'd3);
    checkOutput("t5_midinit_busy", 32'(initBusy), 32'd1);
    reset = 1'b1;
    applyIdle(1);
    releaseReset("t5a", 1'b1);
    applyStimulus(1, 4'd3, 0, 0, 0, 0, 0, 0);
    applyIdle(1);
    checkOutput("t5a_idx3", 32'(colorData), 32'h00ffd7b1);

    // Reset in RUN with a read in flight. The valid must clear immediately.
    applyStimulus(0, 0, 1, 2'd2, 4'd2, 24'h0f0f0f, 0, 0);
    applyStimulus(1, 4'd2, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    applyStimulus(1, 4'd4, 0, 0, 0, 0, 0, 0);
    checkOutput("t5b_valid_cleared", 32'(colorValid), 32'd0);
    checkOutput("t5b_data_cleared", 32'(colorData), 32'd0);
    releaseReset("t5b", 1'b0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 2'd2);
    checkOutput("t5b_bank2", 32'(activeBank), 32'd2);
    applyStimulus(1, 4'd2, 0, 0, 0, 0, 0, 2'd2);
    applyIdle(1);
    checkOutput("t5b_reloaded", 32'(colorData), 32'h00f5d1b9);

    applyIdle(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
